// File: rtl/somador_subtrator_sequencial.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle, LSB first, start/busy/done handshake.
// Exposes the sign bits and Sel_Out that the downstream overflow detector consumes.
module somador_subtrator_sequencial #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             Clock,
    input  logic             Reset_N,
    input  logic             Start,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic             Seletion_Sum_Sub,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Signal_A,
    output logic             Signal_B,
    output logic             Signal_Result,
    output logic             Sel_Out,
    output logic             Carry,
    output logic             Zero,
    output logic             Negative
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_sig_a, r_sig_b, r_sel;

    logic [WIDTH-1:0] r_result;
    logic             r_sig_a_out, r_sig_b_out, r_sig_r_out, r_sel_out;
    logic             r_carry_out, r_zero_out;

    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_last;

    assign w_sum      = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
    assign w_acc_next = {w_sum[CHUNK-1:0], r_acc[WIDTH-1:CHUNK]};
    assign w_last     = (r_cnt == CW'(N - 1));

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        Busy         = 1'b0;
        Done         = 1'b0;
        case (r_state)
            StIdle: begin
                if (Start) w_state_next = StCalc;
            end
            StCalc: begin
                Busy = 1'b1;
                if (w_last) w_state_next = StDone;
            end
            StDone: begin
                Busy         = 1'b1;
                Done         = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sig_a     <= 1'b0;
            r_sig_b     <= 1'b0;
            r_sel       <= 1'b0;
            r_result    <= '0;
            r_sig_a_out <= 1'b0;
            r_sig_b_out <= 1'b0;
            r_sig_r_out <= 1'b0;
            r_sel_out   <= 1'b0;
            r_carry_out <= 1'b0;
            r_zero_out  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (Start) begin
                        // Subtraction runs as A + ~B + 1 via the carry-in.
                        r_a     <= Operand_A;
                        r_b     <= Seletion_Sum_Sub ? ~Operand_B : Operand_B;
                        r_carry <= Seletion_Sum_Sub;
                        r_cnt   <= '0;
                        r_sig_a <= Operand_A[WIDTH-1];
                        r_sig_b <= Operand_B[WIDTH-1];
                        r_sel   <= Seletion_Sum_Sub;
                    end
                end
                StCalc: begin
                    r_acc   <= w_acc_next;
                    r_a     <= r_a >> CHUNK;
                    r_b     <= r_b >> CHUNK;
                    r_carry <= w_sum[CHUNK];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result    <= w_acc_next;
                        r_carry_out <= w_sum[CHUNK];
                        r_zero_out  <= (w_acc_next == '0);
                        r_sig_r_out <= w_acc_next[WIDTH-1];
                        r_sig_a_out <= r_sig_a;
                        r_sig_b_out <= r_sig_b;
                        r_sel_out   <= r_sel;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Result        = r_result;
    assign Signal_A      = r_sig_a_out;
    assign Signal_B      = r_sig_b_out;
    assign Signal_Result = r_sig_r_out;
    assign Negative      = r_sig_r_out;
    assign Sel_Out       = r_sel_out;
    assign Carry         = r_carry_out;
    assign Zero          = r_zero_out;

endmodule

// File: tb/tb_somador_subtrator_sequencial.sv
// Bench for somador_subtrator_sequencial: directed table, random ops against an arithmetic
// model, and hand-written handshake, re-trigger and mid-operation reset sequences.
module tb_somador_subtrator_sequencial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        sel = 1'b0;
    logic        busy, done, sig_a, sig_b, sig_r, sel_out, carry, zero, neg;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    somador_subtrator_sequencial #(.WIDTH(32), .CHUNK(8)) dut (
        .Clock(clk), .Reset_N(rst_n), .Start(start),
        .Operand_A(op_a), .Operand_B(op_b), .Seletion_Sum_Sub(sel),
        .Busy(busy), .Done(done), .Result(result),
        .Signal_A(sig_a), .Signal_B(sig_b), .Signal_Result(sig_r),
        .Sel_Out(sel_out), .Carry(carry), .Zero(zero), .Negative(neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic        sel;
        logic [31:0] res;
        logic        c, z, n, sa, sb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plain arithmetic reference: carry of an unsigned add, or "no borrow" (A >= B) for a subtract.
    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        vec_t        v;
        logic [32:0] wide;
        v.a   = a;
        v.b   = b;
        v.sel = s;
        wide  = {1'b0, a} + {1'b0, b};
        v.res = s ? (a - b) : (a + b);
        v.c   = s ? (a >= b) : wide[32];
        v.z   = (v.res == 32'd0);
        v.n   = v.res[31];
        v.sa  = a[31];
        v.sb  = b[31];
        return v;
    endfunction

    task automatic check_outputs(input vec_t v, input string tag);
        check({tag, ".result"}, result, v.res);
        check({tag, ".carry"}, 32'(carry), 32'(v.c));
        check({tag, ".zero"}, 32'(zero), 32'(v.z));
        check({tag, ".negative"}, 32'(neg), 32'(v.n));
        check({tag, ".sig_r"}, 32'(sig_r), 32'(v.n));
        check({tag, ".sig_a"}, 32'(sig_a), 32'(v.sa));
        check({tag, ".sig_b"}, 32'(sig_b), 32'(v.sb));
        check({tag, ".sel_out"}, 32'(sel_out), 32'(v.sel));
    endtask

    // Wait (bounded) for Done; returns cycles counted from the cycle after capture (1-based).
    task automatic wait_done(output int lat, output int busy_low);
        lat      = 1;
        busy_low = 0;
        while (!done && lat < 12) begin
            if (!busy) busy_low++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int lat, busy_low;
        @(negedge clk);
        op_a  = v.a;
        op_b  = v.b;
        sel   = v.sel;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = ~v.a;
        op_b  = ~v.b;
        sel   = ~v.sel;
        check({tag, ".busy_t1"}, 32'(busy), 32'd1);
        check({tag, ".done_t1"}, 32'(done), 32'd0);
        wait_done(lat, busy_low);
        check({tag, ".latency"}, 32'(lat), 32'd5);
        check({tag, ".busy_low"}, 32'(busy_low), 32'd0);
        check_outputs(v, tag);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
        check({tag, ".hold"}, result, v.res);
    endtask

    initial begin
        vec_t tbl[5];
        vec_t v;
        int   lat, busy_low, idle_cnt, cyc;
        int   done_t[$];

        tbl[0] = '{a: 32'd5,          b: 32'd3, sel: 1'b0, res: 32'd8,
                   c: 1'b0, z: 1'b0, n: 1'b0, sa: 1'b0, sb: 1'b0};
        tbl[1] = '{a: 32'h7FFF_FFFF, b: 32'd1, sel: 1'b0, res: 32'h8000_0000,
                   c: 1'b0, z: 1'b0, n: 1'b1, sa: 1'b0, sb: 1'b0};
        tbl[2] = '{a: 32'd5,          b: 32'd5, sel: 1'b1, res: 32'd0,
                   c: 1'b1, z: 1'b1, n: 1'b0, sa: 1'b0, sb: 1'b0};
        tbl[3] = '{a: 32'd3,          b: 32'd5, sel: 1'b1, res: 32'hFFFF_FFFE,
                   c: 1'b0, z: 1'b0, n: 1'b1, sa: 1'b0, sb: 1'b0};
        tbl[4] = '{a: 32'h8000_0000, b: 32'd1, sel: 1'b1, res: 32'h7FFF_FFFF,
                   c: 1'b1, z: 1'b0, n: 1'b0, sa: 1'b1, sb: 1'b0};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.result", result, 32'd0);
        check("reset.flags", {24'd0, sig_a, sig_b, sig_r, sel_out, carry, zero, neg, 1'b0}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_op(tbl[i], $sformatf("dir%0d", i));

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) ra = 32'hFFFF_FFFF;
            v = model(ra, rb, 1'($urandom_range(0, 1)));
            run_op(v, $sformatf("rnd%0d", i));
        end

        // Start during Busy with new operands is ignored and not queued.
        v = model(32'd10, 32'd20, 1'b0);
        @(negedge clk);
        op_a = 32'd10; op_b = 32'd20; sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op_a = 32'd1000; op_b = 32'd1; sel = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, busy_low);
        check("ignore.latency", 32'(lat + 2), 32'd5);
        check_outputs(v, "ignore");
        idle_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (!busy && !done) idle_cnt++;
        end
        check("ignore.no_queue", 32'(idle_cnt), 32'd4);

        // Start held high re-triggers every N+2 cycles.
        v = model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        op_a = v.a; op_b = v.b; sel = v.sel; start = 1'b1;
        cyc = 0;
        while (done_t.size() < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) done_t.push_back(cyc);
        end
        start = 1'b0;
        check("held.count", 32'(done_t.size()), 32'd3);
        if (done_t.size() == 3) begin
            check("held.first", 32'(done_t[0]), 32'd5);
            check("held.gap1", 32'(done_t[1] - done_t[0]), 32'd6);
            check("held.gap2", 32'(done_t[2] - done_t[1]), 32'd6);
        end
        check_outputs(v, "held");
        @(negedge clk);
        @(negedge clk);
        check("held.stop", 32'(busy), 32'd0);

        // Asynchronous reset in mid-CALC clears everything, no Done.
        @(negedge clk);
        op_a = 32'd7; op_b = 32'd2; sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.result", result, 32'd0);
        check("abort.flags", {24'd0, sig_a, sig_b, sig_r, sel_out, carry, zero, neg, done}, 32'd0);
        idle_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) idle_cnt++;
        end
        check("abort.no_done", 32'(idle_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) idle_cnt++;
        end
        check("abort.after_release", 32'(idle_cnt), 32'd0);
        check("abort.result_held0", result, 32'd0);
        run_op(model(32'd1, 32'd1, 1'b0), "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
